// File: rtl/seg_scan_pkg.sv
// Shared glyph constants, FSM encoding and anode helpers
// for the seven-segment scan capture block.
package seg_scan_pkg;

    // Active-low glyphs, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] NIBBLE_BLANK = 4'hF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] seg;
    } scan_t;

    function automatic logic [3:0] lit_count(input logic [7:0] an);
        logic [3:0] n;
        n = '0;
        for (int k = 0; k < 8; k++)
            n = n + {3'b000, ~an[k]};
        return n;
    endfunction

    function automatic logic [2:0] lit_index(input logic [7:0] an);
        logic [2:0] idx;
        idx = '0;
        for (int k = 7; k >= 0; k--)
            if (!an[k])
                idx = 3'(k);
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_decode.sv
// Seven-segment glyph to nibble decoder; blank and
// unknown codes both yield 4'hF, unknown also flags invalid.
module seg7_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] code,
    output logic [3:0] nibble,
    output logic       invalid
);

    always_comb begin
        nibble  = NIBBLE_BLANK;
        invalid = 1'b0;
        unique case (1'b1)
            (code == GLYPH_0):   nibble = 4'd0;
            (code == GLYPH_1):   nibble = 4'd1;
            (code == GLYPH_2):   nibble = 4'd2;
            (code == GLYPH_3):   nibble = 4'd3;
            (code == GLYPH_4):   nibble = 4'd4;
            (code == GLYPH_5):   nibble = 4'd5;
            (code == GLYPH_6):   nibble = 4'd6;
            (code == GLYPH_7):   nibble = 4'd7;
            (code == GLYPH_8):   nibble = 4'd8;
            (code == GLYPH_9):   nibble = 4'd9;
            (code == SEG_BLANK): nibble = NIBBLE_BLANK;
            default:             invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 8-digit seven-segment scan into nibbles.
// Define SEG_SCAN_ERR_EN to build the sticky error flags.
module seg_scan_capture
    import seg_scan_pkg::*;
#(
    parameter int CLK_FREQ       = 100_000_000,
    parameter int STABLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_in,
    input  logic [7:0]  an_in,
    input  logic        clear_err,
    output logic [31:0] digits_out,
    output logic [7:0]  digit_valid,
    output logic        frame_valid,
    output logic        stale,
    output logic        err_pattern,
    output logic        err_anode
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [14:0] STB_MAX  = '1;
    localparam logic [14:0] STB_LAST = 15'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [7:0]  an_s1, an_s2;
    logic [6:0]  seg_s1, seg_s2;
    scan_t       cur, prev;
    logic [14:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;

    logic        strobe;
    logic [3:0]  lit_n;
    logic [2:0]  lit_idx;
    logic [7:0]  sel;
    logic        smp_one, smp_multi;
    logic [3:0]  dec_nib;
    logic        dec_bad;
    logic        tmo_hit;

    state_t      state, state_nxt;
    logic        do_write, do_complete, do_timeout;
    logic [7:0]  seen;
    logic [31:0] shadow;

    assign cur = {an_s2, seg_s2};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_s1    <= '1;
            an_s2    <= '1;
            seg_s1   <= '1;
            seg_s2   <= '1;
            prev     <= '1;
            stab_cnt <= '0;
        end else begin
            an_s1  <= an_in;
            an_s2  <= an_s1;
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            prev   <= cur;
            if (cur != prev)
                stab_cnt <= '0;
            else if (stab_cnt != STB_MAX)
                stab_cnt <= stab_cnt + 15'd1;
        end
    end

    // prev holds the value the counter has been timing
    assign strobe    = (stab_cnt == STB_LAST);
    assign lit_n     = lit_count(prev.an);
    assign lit_idx   = lit_index(prev.an);
    assign sel       = 8'b1 << lit_idx;
    assign smp_one   = strobe && (lit_n == 4'd1);
    assign smp_multi = strobe && (lit_n > 4'd1);

    seg7_decode u_dec (
        .code    (prev.seg),
        .nibble  (dec_nib),
        .invalid (dec_bad)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            tmo_cnt <= '0;
        else if (smp_one)
            tmo_cnt <= '0;
        else if (tmo_cnt != TMO_LAST)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // A sample beats a timeout landing on the same cycle
    always_comb begin
        state_nxt   = state;
        do_write    = 1'b0;
        do_complete = 1'b0;
        do_timeout  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (smp_one) begin
                    do_write  = 1'b1;
                    state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (smp_one) begin
                    do_write    = 1'b1;
                    do_complete = seen[lit_idx];
                end else if (tmo_hit) begin
                    do_timeout = 1'b1;
                    state_nxt  = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen        <= '0;
            shadow      <= '1;
            digits_out  <= '1;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            stale       <= 1'b1;
        end else begin
            frame_valid <= do_complete;
            if (do_complete) begin
                digits_out  <= shadow;
                digit_valid <= seen;
                stale       <= 1'b0;
            end
            if (do_write) begin
                shadow[{lit_idx, 2'b00} +: 4] <= dec_nib;
                seen <= do_complete ? sel : (seen | sel);
            end else if (do_timeout) begin
                seen        <= '0;
                digit_valid <= '0;
                stale       <= 1'b1;
            end
        end
    end

`ifdef SEG_SCAN_ERR_EN
    // A fresh error outranks a clear pulse on the same cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_pattern <= 1'b0;
            err_anode   <= 1'b0;
        end else begin
            if (smp_one && dec_bad)
                err_pattern <= 1'b1;
            else if (clear_err)
                err_pattern <= 1'b0;
            if (smp_multi)
                err_anode <= 1'b1;
            else if (clear_err)
                err_anode <= 1'b0;
        end
    end
`else
    logic unused_err;
    assign unused_err  = ^{clear_err, dec_bad, smp_multi};
    assign err_pattern = 1'b0;
    assign err_anode   = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: directed vector table, corner
// sequences, and random scans against an event-level model.
module tb_seg_scan_capture;

    localparam int S = 64;
    localparam int T = 3000;

`ifdef SEG_SCAN_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [6:0] GL [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000
    };

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [7:0]  an_in;
    logic        clear_err;
    logic [31:0] digits_out;
    logic [7:0]  digit_valid;
    logic        frame_valid, stale, err_pattern, err_anode;

    seg_scan_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .clear_err   (clear_err),
        .digits_out  (digits_out),
        .digit_valid (digit_valid),
        .frame_valid (frame_valid),
        .stale       (stale),
        .err_pattern (err_pattern),
        .err_anode   (err_anode)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp_v);
        n_total++;
        if (act === exp_v)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", nm, act, exp_v);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [14:0] v;
    } ev_t;

    ev_t         m_q[$];
    ev_t         ev;
    logic [31:0] m_dig, m_shadow;
    logic [7:0]  m_dv, m_seen;
    logic        m_fv, m_stale, m_ep, m_ea, m_coll;
    int          m_edge = 0, m_tlast, m_run;
    logic [14:0] m_pv, m_cur;
    bit          m_pv_ok, m_vs, m_go = 1'b0;
    logic [3:0]  m_nib;
    int          m_idx, m_lit;

    function automatic int zeros(input logic [7:0] an);
        int n = 0;
        for (int k = 0; k < 8; k++)
            if (!an[k]) n++;
        return n;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_dig = '1; m_shadow = '1; m_dv = '0; m_seen = '0;
            m_fv = 0; m_stale = 1; m_ep = 0; m_ea = 0; m_coll = 0;
            m_tlast = 0; m_run = 0; m_pv_ok = 0;
        end else begin
            m_edge++;
            m_fv = 0;
            m_vs = 0;
            if (ERR_EN && clear_err) begin
                m_ep = 0;
                m_ea = 0;
            end
            if (m_q.size() > 0 && m_q[0].due == m_edge) begin
                ev = m_q.pop_front();
                m_lit = zeros(ev.v[14:7]);
                if (m_lit >= 2) begin
                    if (ERR_EN) m_ea = 1;
                end else if (m_lit == 1) begin
                    for (int k = 0; k < 8; k++)
                        if (!ev.v[7 + k]) m_idx = k;
                    m_nib = 4'hF;
                    if (ev.v[6:0] != 7'h7F) begin
                        if (ERR_EN) m_ep = 1;
                        for (int g = 0; g < 10; g++)
                            if (ev.v[6:0] == GL[g]) begin
                                m_nib = 4'(g);
                                m_ep  = m_ep;
                            end
                    end
                    if (ERR_EN && ev.v[6:0] != 7'h7F) begin
                        m_ep = (m_nib == 4'hF) ? 1'b1 : m_ep;
                    end
                    m_vs = 1;
                    m_tlast = m_edge;
                    if (m_coll && m_seen[m_idx]) begin
                        m_dig = m_shadow;
                        m_dv = m_seen;
                        m_fv = 1;
                        m_stale = 0;
                        m_seen = '0;
                    end
                    m_seen[m_idx] = 1'b1;
                    m_shadow[m_idx*4 +: 4] = m_nib;
                    m_coll = 1;
                end
            end
            if (!m_vs && m_coll && (m_edge - m_tlast == T)) begin
                m_coll = 0;
                m_seen = '0;
                m_stale = 1;
                m_dv = '0;
            end
            m_cur = {an_in, seg_in};
            if (m_pv_ok && m_cur == m_pv) m_run++;
            else m_run = 1;
            m_pv = m_cur;
            m_pv_ok = 1;
            if (m_run == S) m_q.push_back('{m_edge + 3, m_cur});
        end
    end

    always @(negedge clk)
        if (reset_n === 1'b1 && m_go)
            check("model",
                  64'({digits_out, digit_valid, frame_valid,
                       stale, err_pattern, err_anode}),
                  64'({m_dig, m_dv, m_fv, m_stale, m_ep, m_ea}));

    int fv_cnt = 0;
    always @(posedge clk)
        if (frame_valid === 1'b1) fv_cnt++;

    // ---------------- stimulus ----------------
    task automatic hold(input logic [7:0] a, input logic [6:0] s,
                        input int n, input bit clr);
        an_in = a;
        seg_in = s;
        clear_err = clr;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset_vals();
        check("rst_digits", 64'(digits_out), 64'hFFFF_FFFF);
        check("rst_dvalid", 64'(digit_valid), 64'h0);
        check("rst_fvalid", 64'(frame_valid), 64'h0);
        check("rst_stale", 64'(stale), 64'h1);
        check("rst_errs", 64'({err_pattern, err_anode}), 64'h0);
    endtask

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  seg;
        int          cyc;
        logic [31:0] dig;
        logic [7:0]  dv;
        logic        st;
    } vec_t;

    vec_t tbl[9];
    int   base, lat;
    logic [7:0] ra;
    logic [6:0] rs;
    int   ri, rj, rk, rn;

    initial begin
        tbl[0] = '{8'hFE, GL[3], 100, 32'hFFFF_FFFF, 8'h00, 1'b1};
        tbl[1] = '{8'hFD, GL[5], 100, 32'hFFFF_FFFF, 8'h00, 1'b1};
        tbl[2] = '{8'hFB, GL[1], 100, 32'hFFFF_FFFF, 8'h00, 1'b1};
        tbl[3] = '{8'hF7, GL[2], 100, 32'hFFFF_FFFF, 8'h00, 1'b1};
        tbl[4] = '{8'hFE, GL[3], 100, 32'hFFFF_2153, 8'h0F, 1'b0};
        tbl[5] = '{8'hFD, GL[5], 100, 32'hFFFF_2153, 8'h0F, 1'b0};
        tbl[6] = '{8'hFB, GL[1], 100, 32'hFFFF_2153, 8'h0F, 1'b0};
        tbl[7] = '{8'hF7, GL[2], 100, 32'hFFFF_2153, 8'h0F, 1'b0};
        tbl[8] = '{8'hFE, GL[3], 100, 32'hFFFF_2153, 8'h0F, 1'b0};

        reset_n = 1'b0;
        an_in = 8'hFF;
        seg_in = 7'h7F;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset_n = 1'b1;
        m_go = 1'b1;
        hold(8'hFF, 7'h7F, 5, 1'b0);

        // four-digit scan laps
        base = fv_cnt;
        for (int i = 0; i < 9; i++) begin
            hold(tbl[i].an, tbl[i].seg, tbl[i].cyc, 1'b0);
            check($sformatf("vec%0d_digits", i), 64'(digits_out),
                  64'(tbl[i].dig));
            check($sformatf("vec%0d_dvalid", i), 64'(digit_valid),
                  64'(tbl[i].dv));
            check($sformatf("vec%0d_stale", i), 64'(stale),
                  64'(tbl[i].st));
        end
        check("lap_fv_count", 64'(fv_cnt - base), 64'd2);

        // pin change to frame_valid latency
        hold(8'hFD, GL[5], 100, 1'b0);
        hold(8'hFB, GL[1], 100, 1'b0);
        hold(8'hF7, GL[2], 100, 1'b0);
        an_in = 8'hFE;
        seg_in = GL[3];
        lat = -1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (frame_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(S + 3));
        repeat (20) @(negedge clk);

        // bouncing segments never settle
        base = fv_cnt;
        for (int i = 0; i < 20; i++)
            hold(8'hFE, (i % 2) ? GL[8] : GL[0], 10, 1'b0);
        check("bounce_no_fv", 64'(fv_cnt - base), 64'd0);

        // two anodes lit at once
        hold(8'hFC, GL[8], 100, 1'b0);
        check("multi_an_err", 64'(err_anode), 64'(ERR_EN));
        check("multi_an_nofv", 64'(fv_cnt - base), 64'd0);
        check("multi_an_digits", 64'(digits_out), 64'hFFFF_2153);
        hold(8'hFC, GL[8], 5, 1'b1);
        check("clear_err", 64'(err_anode), 64'h0);

        // unknown glyph on digit 0
        hold(8'hFE, 7'b0101010, 100, 1'b0);
        check("bad_glyph_err", 64'(err_pattern), 64'(ERR_EN));
        hold(8'hFD, GL[5], 100, 1'b0);
        hold(8'hFE, GL[3], 100, 1'b0);
        check("bad_glyph_digits", 64'(digits_out), 64'hFFFF_215F);
        check("bad_glyph_dvalid", 64'(digit_valid), 64'h03);
        check("pre_tmo_stale", 64'(stale), 64'h0);

        // scan stops: frame goes stale
        hold(8'hFF, 7'h7F, T + 50, 1'b0);
        check("tmo_stale", 64'(stale), 64'h1);
        check("tmo_dvalid", 64'(digit_valid), 64'h0);
        check("tmo_digits", 64'(digits_out), 64'hFFFF_215F);

        // reset part way through a frame
        hold(8'hFE, GL[3], 100, 1'b0);
        hold(8'hFD, GL[5], 100, 1'b0);
        hold(8'hFB, GL[1], 30, 1'b0);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(negedge clk);
        reset_n = 1'b1;
        base = fv_cnt;
        for (int i = 0; i < 5; i++)
            hold(tbl[i].an, tbl[i].seg, 100, 1'b0);
        check("post_rst_fv", 64'(fv_cnt - base), 64'd1);
        check("post_rst_digits", 64'(digits_out), 64'hFFFF_2153);
        check("post_rst_dvalid", 64'(digit_valid), 64'h0F);

        // random scans, checked every cycle by the model
        for (int i = 0; i < 150; i++) begin
            rk = $urandom_range(0, 9);
            ri = $urandom_range(0, 7);
            if (rk < 2) begin
                ra = 8'hFF;
            end else if (rk == 2) begin
                rj = (ri + 1 + $urandom_range(0, 6)) % 8;
                ra = ~((8'b1 << ri) | (8'b1 << rj));
            end else begin
                ra = ~(8'b1 << ri);
            end
            rk = $urandom_range(0, 9);
            if (rk == 0) rs = 7'h7F;
            else if (rk == 1) rs = 7'($urandom);
            else rs = GL[$urandom_range(0, 9)];
            rn = $urandom_range(1, 140);
            if (ra == 8'hFF && $urandom_range(0, 19) == 0)
                rn = T + 100;
            hold(ra, rs, rn, $urandom_range(0, 9) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, system clock in Hz (documentation and derived defaults only).
REQ-002 SHALL have parameter STABLE_CYCLES, default 64, consecutive unchanged cycles required before sampling the scan bus.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, cycles without a digit sample before the captured frame is declared stale.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 seg_in  in  7  multiplexed segment bus, active low, bit order {g,f,e,d,c,b,a}.
REQ-007 an_in  in  8  anode enables, active low, bit 0 = rightmost digit.
REQ-008 clear_err  in  1  one-cycle pulse clearing the sticky error flags.
REQ-009 digits_out  out  32  eight captured nibbles; nibble i = digit i; 4'hF = blank or undecodable.
REQ-010 digit_valid  out  8  bit i set = digit i was lit in the last completed frame.
REQ-011 frame_valid  out  1  one-cycle pulse when digits_out/digit_valid update.
REQ-012 stale  out  1  high while no frame is current (after reset or timeout).
REQ-013 err_pattern  out  1  sticky: a sampled segment code matched no known glyph.
REQ-014 err_anode  out  1  sticky: a sample had more than one anode low.

Function
REQ-015 an_in and seg_in SHALL pass through a two-flop synchronizer before any other use.
REQ-016 A 15-bit stability counter SHALL clear whenever the synchronized {an,seg} differs from its previous-cycle value, and SHALL increment otherwise, saturating.
REQ-017 A single sample strobe SHALL fire on the cycle the counter reaches STABLE_CYCLES-1; no further strobe until the bus changes.
REQ-018 On a strobe with an = 8'hFF the sample SHALL be ignored (inter-digit blanking).
REQ-019 On a strobe with exactly one anode low at index i, the decoded nibble SHALL be written to shadow slot i and seen-mask bit i set.
REQ-020 Decode SHALL map the ten standard active-low glyphs (0=1000000 … 9=0010000) to 0-9, 1111111 to 4'hF, any other code to 4'hF plus err_pattern set.
REQ-021 On a strobe with two or more anodes low, nothing SHALL be written and err_anode SHALL be set.
REQ-022 FSM states IDLE and COLLECT; reset enters IDLE; first valid digit sample moves IDLE->COLLECT.
REQ-023 In COLLECT, a valid sample whose index i is already set in the seen mask SHALL complete the frame: shadow -> digits_out, seen mask -> digit_valid, frame_valid pulsed next cycle, stale cleared, seen mask reloaded with only bit i, slot i rewritten.
REQ-024 The timeout counter SHALL clear on every valid digit sample; on reaching TIMEOUT_CYCLES-1 in COLLECT: FSM -> IDLE, seen mask cleared, stale set, digit_valid cleared, digits_out held.
REQ-025 Timeout and a valid sample in the same cycle: the sample SHALL win.
REQ-026 clear_err and a new error in the same cycle: the error SHALL win.
REQ-027 Latency pin-change to frame_valid SHALL be 2 + STABLE_CYCLES + 1 cycles for the frame-completing digit.

Reset
REQ-028 On reset_n low: digits_out = 32'hFFFF_FFFF, digit_valid = 0, frame_valid = 0, stale = 1, err_pattern = 0, err_anode = 0, FSM = IDLE, all counters, synchronizers (to all ones) and shadow slots (4'hF) cleared; reset mid-frame discards the partial frame.

Configuration
REQ-029 Macro SEG_SCAN_ERR_EN defined: err_pattern/err_anode logic present per REQ-020/021/026.
REQ-030 SEG_SCAN_ERR_EN undefined: err_pattern and err_anode tied 0, clear_err ignored; multi-anode samples still discarded, unknown codes still decode to 4'hF.

Structure
REQ-031 Package seg_scan_pkg SHALL hold the ten glyph constants, SEG_BLANK, NIBBLE_BLANK = 4'hF, and the FSM state encoding.
REQ-032 Sub-module seg7_decode (combinational: 7-bit code -> nibble + invalid flag) SHALL be instantiated once.

Verification
REQ-033 Scan 4 digits an=FE/FD/FB/F7 with glyphs 3,5,1,2 for 100 cycles each, repeat -> frame_valid once per lap, digits_out[15:0]=16'h2153, digit_valid=8'h0F.
REQ-034 Toggle seg every 10 cycles (< STABLE_CYCLES) on an=FE -> no shadow write, no frame_valid.
REQ-035 an=FC with glyph 8 -> err_anode=1, no capture; clear_err pulse -> err_anode=0.
REQ-036 an=FE, seg=0101010 -> slot 0 = 4'hF, err_pattern=1 (0 when SEG_SCAN_ERR_EN undefined).
REQ-037 Complete one frame, then hold an=FF for TIMEOUT_CYCLES -> stale=1, digit_valid=0, digits_out unchanged.
REQ-038 Assert reset_n low mid-frame after 2 digits -> all outputs at REQ-028 values; next full lap yields exactly one frame_valid.
